// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters, one op in flight.
// Ports: clk, reset (async, active-high), req0/req1 valid/ready/a/b/shamt/
//   alucontrol, rsp0/rsp1 valid/ready/result/zero, alu_a/b/shamt/alucontrol
//   to the ALU, alu_result/alu_zero from the ALU, gnt_cnt0/gnt_cnt1 counters.
// Macro ALU_ARB_RR_EN: defined -> round-robin ties, undefined -> port 0 wins.
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic [3:0]       req0_alucontrol,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [4:0]       req1_shamt,
  input  logic [3:0]       req1_alucontrol,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_zero,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_zero,

  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_alucontrol,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,

  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic win;
  logic grant;
  logic capture;
  logic owner_q;

  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [4:0]  sh_q;
  logic [3:0]  ctl_q;
  logic [31:0] res_q;
  logic        zero_q;

  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // winner selection: win=0 -> port 0, win=1 -> port 1
`ifdef ALU_ARB_RR_EN
  logic last_q;

  // ties go to the port that was not granted most recently
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid):  win = ~last_q;
      (req0_valid && !req1_valid): win = 1'b0;
      default:                     win = 1'b1;
    endcase
  end

  // reset to 1 so port 0 takes the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= win;
    end
  end
`else
  always_comb begin
    win = ~req0_valid;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    capture    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant      = 1'b1;
          req0_ready = ~win;
          req1_ready = win;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // only the owner's ready can release the response
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // operand register: sole source of the alu_* outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sh_q    <= '0;
      ctl_q   <= '0;
    end else if (grant) begin
      owner_q <= win;
      opa_q   <= win ? req1_a : req0_a;
      opb_q   <= win ? req1_b : req0_b;
      sh_q    <= win ? req1_shamt : req0_shamt;
      ctl_q   <= win ? req1_alucontrol : req0_alucontrol;
    end
  end

  // response register: loaded once in EXEC, held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (capture) begin
      res_q  <= alu_result;
      zero_q <= alu_zero;
    end
  end

  // saturating grant counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
    end else if (grant && !win && (cnt0_q != '1)) begin
      cnt0_q <= cnt0_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt1_q <= '0;
    end else if (grant && win && (cnt1_q != '1)) begin
      cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign alu_a          = opa_q;
  assign alu_b          = opb_q;
  assign alu_shamt      = sh_q;
  assign alu_alucontrol = ctl_q;

  assign rsp0_valid  = (state_q == RESP) && !owner_q;
  assign rsp1_valid  = (state_q == RESP) && owner_q;
  assign rsp0_result = owner_q ? '0 : res_q;
  assign rsp1_result = owner_q ? res_q : '0;
  assign rsp0_zero   = ~owner_q & zero_q;
  assign rsp1_zero   = owner_q & zero_q;

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter.
// A second instance with CNT_W=2 shares the stimulus to check saturation.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  pv = 2'b00;
  logic [1:0]  rr = 2'b00;
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [4:0]  ps [2];
  logic [3:0]  pc [2];

  logic [3:0] codes [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b1010,
                            4'b0011, 4'b0100, 4'b0110};

  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_alucontrol;
  logic        alu_zero;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  logic        d2_req0_ready, d2_req1_ready;
  logic        d2_rsp0_valid, d2_rsp1_valid, d2_rsp0_zero, d2_rsp1_zero;
  logic [31:0] d2_rsp0_result, d2_rsp1_result;
  logic [31:0] d2_alu_a, d2_alu_b, d2_alu_result;
  logic [4:0]  d2_alu_shamt;
  logic [3:0]  d2_alu_alucontrol;
  logic        d2_alu_zero;
  logic [1:0]  d2_gnt_cnt0, d2_gnt_cnt1;

  int checks = 0;
  int failures = 0;
  int mlast = 1;
  int mcnt [2] = '{0, 0};

  // behavioural stand-in for the shared ALU
  function automatic logic [32:0] alu_f(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [4:0]  s,
                                        input logic [3:0]  c);
    logic [31:0] r;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b1010: r = a - b;
      4'b0011: r = a << s;
      4'b0100: r = a >> s;
      default: r = a ^ b;
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result} =
    alu_f(alu_a, alu_b, alu_shamt, alu_alucontrol);
  assign {d2_alu_zero, d2_alu_result} =
    alu_f(d2_alu_a, d2_alu_b, d2_alu_shamt, d2_alu_alucontrol);

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(pv[0]), .req0_ready(req0_ready),
    .req0_a(pa[0]), .req0_b(pb[0]),
    .req0_shamt(ps[0]), .req0_alucontrol(pc[0]),
    .req1_valid(pv[1]), .req1_ready(req1_ready),
    .req1_a(pa[1]), .req1_b(pb[1]),
    .req1_shamt(ps[1]), .req1_alucontrol(pc[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_shamt(alu_shamt), .alu_alucontrol(alu_alucontrol),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  alu_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .req0_valid(pv[0]), .req0_ready(d2_req0_ready),
    .req0_a(pa[0]), .req0_b(pb[0]),
    .req0_shamt(ps[0]), .req0_alucontrol(pc[0]),
    .req1_valid(pv[1]), .req1_ready(d2_req1_ready),
    .req1_a(pa[1]), .req1_b(pb[1]),
    .req1_shamt(ps[1]), .req1_alucontrol(pc[1]),
    .rsp0_valid(d2_rsp0_valid), .rsp0_ready(rr[0]),
    .rsp0_result(d2_rsp0_result), .rsp0_zero(d2_rsp0_zero),
    .rsp1_valid(d2_rsp1_valid), .rsp1_ready(rr[1]),
    .rsp1_result(d2_rsp1_result), .rsp1_zero(d2_rsp1_zero),
    .alu_a(d2_alu_a), .alu_b(d2_alu_b),
    .alu_shamt(d2_alu_shamt), .alu_alucontrol(d2_alu_alucontrol),
    .alu_result(d2_alu_result), .alu_zero(d2_alu_zero),
    .gnt_cnt0(d2_gnt_cnt0), .gnt_cnt1(d2_gnt_cnt1)
  );

  function automatic int exp_winner(input logic v0, input logic v1);
    if (v0 && !v1) return 0;
    if (!v0 && v1) return 1;
`ifdef ALU_ARB_RR_EN
    return (mlast == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  function automatic int sat2(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic new_op(input int p);
    pa[p] = $urandom;
    pb[p] = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom;
    ps[p] = 5'($urandom_range(0, 31));
    pc[p] = codes[$urandom_range(0, 6)];
    pv[p] = 1'b1;
  endtask

  task automatic model_reset();
    mlast = 1;
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  task automatic serve(input bit refill, input bit poke,
                       input int hold, output int w);
    int ew;
    bit got;
    logic [31:0] ea, eb, er, rv;
    logic [4:0] es;
    logic [3:0] ec;
    logic ez, rz;
    logic [32:0] t;
    logic [1:0] ev;
    got = 0;
    w = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_timeout ready=%b%b required=some ready",
               req1_ready, req0_ready);
      return;
    end
    w = req1_ready ? 1 : 0;
    ew = exp_winner(pv[0], pv[1]);
    checks++;
    if (w != ew || (req0_ready && req1_ready)) begin
      failures++;
      $display("FAIL winner got=%0d ready=%b%b required=%0d",
               w, req1_ready, req0_ready, ew);
    end
    ea = pa[w]; eb = pb[w]; es = ps[w]; ec = pc[w];
    t = alu_f(ea, eb, es, ec);
    er = t[31:0];
    ez = t[32];
    mlast = w;
    mcnt[w]++;
    ev = (w == 1) ? 2'b10 : 2'b01;

    @(posedge clk); #1;
    if (refill) new_op(w);
    else pv[w] = 1'b0;
    if (poke) new_op(1 - w);
    if (!refill) begin
      pa[w] = $urandom;
      pb[w] = $urandom;
    end
    rr = 2'b11;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_shamt, alu_alucontrol} !== {ea, eb, es, ec}) begin
      failures++;
      $display("FAIL alu_operands got=%h %h %h %h required=%h %h %h %h",
               alu_a, alu_b, alu_shamt, alu_alucontrol, ea, eb, es, ec);
    end
    checks++;
    if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 4'b0) begin
      failures++;
      $display("FAIL exec_outputs got=%b%b%b%b required=0000",
               rsp1_valid, rsp0_valid, req1_ready, req0_ready);
    end
    checks++;
    if (gnt_cnt0 !== 16'(sat16(mcnt[0])) ||
        gnt_cnt1 !== 16'(sat16(mcnt[1]))) begin
      failures++;
      $display("FAIL gnt_cnt got=%0d,%0d required=%0d,%0d",
               gnt_cnt0, gnt_cnt1, sat16(mcnt[0]), sat16(mcnt[1]));
    end
    checks++;
    if (d2_gnt_cnt0 !== 2'(sat2(mcnt[0])) ||
        d2_gnt_cnt1 !== 2'(sat2(mcnt[1]))) begin
      failures++;
      $display("FAIL gnt_cnt_w2 got=%0d,%0d required=%0d,%0d",
               d2_gnt_cnt0, d2_gnt_cnt1, sat2(mcnt[0]), sat2(mcnt[1]));
    end

    @(posedge clk); #1;
    rr[w] = 1'b0;
    #1;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge clk); #2;
      end
      rv = (w == 1) ? rsp1_result : rsp0_result;
      rz = (w == 1) ? rsp1_zero : rsp0_zero;
      checks++;
      if ({rsp1_valid, rsp0_valid} !== ev ||
          {req1_ready, req0_ready} !== 2'b00) begin
        failures++;
        $display("FAIL resp_valid cyc=%0d got=%b%b rdy=%b%b required=%b 00",
                 h, rsp1_valid, rsp0_valid, req1_ready, req0_ready, ev);
      end
      checks++;
      if (rv !== er || rz !== ez) begin
        failures++;
        $display("FAIL resp_data cyc=%0d got=%h/%b required=%h/%b",
                 h, rv, rz, er, ez);
      end
    end

    rr[w] = 1'b1;
    @(posedge clk); #1;
    rr = 2'b00;
    #1;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      failures++;
      $display("FAIL release got=%b%b required=00", rsp1_valid, rsp0_valid);
    end
  endtask

  task automatic do_reset();
    pv = 2'b00;
    rr = 2'b00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 4'b0 ||
        {rsp0_result, rsp1_result, rsp0_zero, rsp1_zero} !== 66'd0) begin
      failures++;
      $display("FAIL reset_rsp got=%b%b%b%b %h %h required=0",
               rsp1_valid, rsp0_valid, req1_ready, req0_ready,
               rsp0_result, rsp1_result);
    end
    checks++;
    if ({alu_a, alu_b, alu_shamt, alu_alucontrol} !== 73'd0 ||
        gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL reset_regs got=%h %h %h %h %0d %0d required=0",
               alu_a, alu_b, alu_shamt, alu_alucontrol, gnt_cnt0, gnt_cnt1);
    end
  endtask

  task automatic test_add();
    int w;
    pa[0] = 32'd5; pb[0] = 32'd7; ps[0] = 5'd0; pc[0] = 4'b0010;
    pv[0] = 1'b1;
    serve(0, 0, 0, w);
    checks++;
    if (gnt_cnt0 !== 16'd1 || w != 0) begin
      failures++;
      $display("FAIL add_cnt got=%0d w=%0d required=1 w=0", gnt_cnt0, w);
    end
  endtask

  task automatic test_sub_hold();
    int w;
    pa[1] = 32'd9; pb[1] = 32'd9; ps[1] = 5'd0; pc[1] = 4'b1010;
    pv[1] = 1'b1;
    serve(0, 1, 5, w);
    serve(0, 0, 0, w);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL held_req0 got=%0d required=0", w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int order [4];
`ifdef ALU_ARB_RR_EN
    int exp_order [4] = '{0, 1, 0, 1};
`else
    int exp_order [4] = '{0, 0, 0, 0};
`endif
    do_reset();
    new_op(0);
    new_op(1);
    for (int i = 0; i < 4; i++) begin
      serve(1, 0, 0, w);
      order[i] = w;
    end
    pv = 2'b00;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        failures++;
        $display("FAIL grant_order idx=%0d got=%0d required=%0d",
                 i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_random();
    int w;
    for (int i = 0; i < 30; i++) begin
      if (pv == 2'b00) begin
        case ($urandom_range(0, 2))
          0: new_op(0);
          1: new_op(1);
          default: begin
            new_op(0);
            new_op(1);
          end
        endcase
      end
      serve(1'($urandom_range(0, 1)), 0, $urandom_range(0, 3), w);
    end
    pv = 2'b00;
  endtask

  task automatic test_reset_exec();
    bit got;
    got = 0;
    new_op(0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req0_ready) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL rst_grant_timeout ready=%b required=1", req0_ready);
    end
    @(posedge clk); #1;
    pv = 2'b00;
    reset = 1'b1;
    #1;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00 || gnt_cnt0 !== 16'd0 ||
        gnt_cnt1 !== 16'd0 || d2_gnt_cnt0 !== 2'd0 ||
        {alu_a, alu_b, alu_shamt, alu_alucontrol} !== 73'd0) begin
      failures++;
      $display("FAIL reset_exec got=%b%b %0d %0d %0d %h required=0",
               rsp1_valid, rsp0_valid, gnt_cnt0, gnt_cnt1,
               d2_gnt_cnt0, alu_a);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    rr = 2'b11;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 4'b0) begin
        failures++;
        $display("FAIL stale_resp cyc=%0d got=%b%b%b%b required=0000",
                 n, rsp1_valid, rsp0_valid, req1_ready, req0_ready);
      end
    end
    rr = 2'b00;
  endtask

  task automatic test_saturate();
    int w;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      new_op(0);
      serve(0, 0, 0, w);
      checks++;
      if (d2_gnt_cnt0 !== exp_cnt[i]) begin
        failures++;
        $display("FAIL sat_cnt idx=%0d got=%0d required=%0d",
                 i, d2_gnt_cnt0, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      pa[p] = '0; pb[p] = '0; ps[p] = '0; pc[p] = '0;
    end
    test_reset();
    test_add();
    test_sub_hold();
    test_back_to_back();
    test_random();
    test_reset_exec();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
